// File: rtl/uart_rx_pkg.sv
// Shared types and frame-format helpers for the UART RX frame timer.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  localparam int START_BITS    = 1;
  localparam int STOP_BITS_MIN = 1;

  function automatic int frame_len(
    input int   data_len,
    input logic par_en,
    input logic stop2
  );
    return START_BITS + data_len + int'(par_en)
         + STOP_BITS_MIN + int'(stop2);
  endfunction

endpackage

// File: rtl/uart_rx_frame_timer_if.sv
// Control/status bundle between the RX FSM, the frame timer and the sampler.
interface uart_rx_frame_timer_if #(
  parameter int PRESC_W = 6,
  parameter int BIT_W   = 4
);

  logic               EN;
  logic [PRESC_W-1:0] Prescale;
  logic [BIT_W-1:0]   Data_Len;
  logic               Par_En;
  logic               Stop2;
  logic [BIT_W-1:0]   bit_count;
  logic [PRESC_W-1:0] edge_count;
  logic               edge_end;
  logic               sample_stb;
  logic               sample_last;
  logic               frame_end;
  logic               busy;
  logic               cfg_err;

  modport master (
    output EN, Prescale, Data_Len, Par_En, Stop2,
    input  bit_count, edge_count, edge_end,
    input  sample_stb, sample_last, frame_end,
    input  busy, cfg_err
  );

  modport slave (
    input  EN, Prescale, Data_Len, Par_En, Stop2,
    output bit_count, edge_count, edge_end,
    output sample_stb, sample_last, frame_end,
    output busy, cfg_err
  );

endinterface

// File: rtl/uart_rx_edge_ctr.sv
// Modulo-presc edge counter: runs 1..presc while enabled, parks at 1 otherwise.
module uart_rx_edge_ctr #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic [W-1:0] presc,
  output logic [W-1:0] edge_count,
  output logic         edge_end
);

  assign edge_end = run && (edge_count == presc);

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      edge_count <= W'(1);
    end else if (edge_end) begin
      edge_count <= W'(1);
    end else begin
      edge_count <= edge_count + W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_frame_timer.sv
// UART RX frame timer: bit/edge counting, sample strobes, end-of-frame pulse.
// Define UART_RX_TRIPLE_SAMPLE_EN for three strobes per bit (majority vote).
module uart_rx_frame_timer
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W   = 6,
  parameter int BIT_W     = 4,
  parameter int MAX_DATA  = 8,
  parameter int MIN_PRESC = 4
) (
  input logic                   CLK,
  input logic                   Reset,
  uart_rx_frame_timer_if.slave  bus
);

  localparam logic [BIT_W-1:0]   DMIN = BIT_W'(5);
  localparam logic [BIT_W-1:0]   DMAX = BIT_W'(MAX_DATA);
  localparam logic [PRESC_W-1:0] PMIN = PRESC_W'(MIN_PRESC);

  state_t             state_q;
  state_t             state_d;
  logic [PRESC_W-1:0] presc_q;
  logic [BIT_W-1:0]   flen_q;
  logic [BIT_W-1:0]   bit_q;
  logic               cfg_err_q;

  logic               cfg_ok;
  logic               start;
  logic               run;
  logic               last_bit;
  logic               edge_end;
  logic               frame_end;
  logic [PRESC_W-1:0] edge_count;
  logic [PRESC_W-1:0] mid;
  logic               stb_hit;
  logic               last_hit;

  assign cfg_ok = (bus.Prescale >= PMIN)
               && (bus.Data_Len >= DMIN)
               && (bus.Data_Len <= DMAX);

  assign start    = (state_q == IDLE) && bus.EN && cfg_ok;
  assign run      = (state_q == COUNT) && bus.EN;
  assign last_bit = (bit_q == flen_q - BIT_W'(1));

  uart_rx_edge_ctr #(
    .W (PRESC_W)
  ) u_edge (
    .clk        (CLK),
    .rst        (Reset),
    .run        (run),
    .presc      (presc_q),
    .edge_count (edge_count),
    .edge_end   (edge_end)
  );

  assign frame_end = edge_end && last_bit;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = COUNT;
      COUNT: begin
        if (!bus.EN)        state_d = IDLE;
        else if (frame_end) state_d = DONE;
      end
      DONE:    if (!bus.EN) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= IDLE;
      bit_q     <= '0;
      presc_q   <= '0;
      flen_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        presc_q <= bus.Prescale;
        flen_q  <= BIT_W'(frame_len(int'(bus.Data_Len),
                                    bus.Par_En, bus.Stop2));
      end
      if ((state_q == IDLE) && bus.EN && !cfg_ok)
        cfg_err_q <= 1'b1;
      // DONE with EN still high freezes bit_count on the last bit
      if (!run) begin
        if ((state_q != DONE) || !bus.EN)
          bit_q <= '0;
      end else if (edge_end && !last_bit) begin
        bit_q <= bit_q + BIT_W'(1);
      end
    end
  end

  assign mid = presc_q >> 1;

`ifdef UART_RX_TRIPLE_SAMPLE_EN
  assign stb_hit  = (edge_count == mid - PRESC_W'(1))
                 || (edge_count == mid)
                 || (edge_count == mid + PRESC_W'(1));
  assign last_hit = (edge_count == mid + PRESC_W'(1));
`else
  assign stb_hit  = (edge_count == mid);
  assign last_hit = stb_hit;
`endif

  assign bus.bit_count   = bit_q;
  assign bus.edge_count  = edge_count;
  assign bus.edge_end    = edge_end;
  assign bus.sample_stb  = run && stb_hit;
  assign bus.sample_last = run && last_hit;
  assign bus.frame_end   = frame_end;
  assign bus.busy        = (state_q == COUNT);
  assign bus.cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// Scoreboard bench for uart_rx_frame_timer: strobe and frame-end queues.
module tb_uart_rx_frame_timer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_rx_frame_timer_if #(.PRESC_W(6), .BIT_W(4)) bus ();

  uart_rx_frame_timer #(
    .PRESC_W   (6),
    .BIT_W     (4),
    .MAX_DATA  (8),
    .MIN_PRESC (4)
  ) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int stb_q[$];
  int fe_q[$];
  int busy_cyc = 0;
  int fe_seen  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy && bus.EN) busy_cyc++;
      else if (!bus.busy) busy_cyc = 0;
      if (bus.sample_stb) begin
        if (stb_q.size() == 0) check("stb_extra", 1, 0);
        else check("stb",
                   int'(bus.bit_count) * 1024
                   + int'(bus.edge_count) * 2
                   + int'(bus.sample_last),
                   stb_q.pop_front());
      end
      if (bus.frame_end) begin
        fe_seen++;
        if (fe_q.size() == 0) check("fe_extra", 1, 0);
        else check("fe",
                   busy_cyc * 65536
                   + int'(bus.bit_count) * 256
                   + int'(bus.edge_count),
                   fe_q.pop_front());
      end
    end
  end

  task automatic push_bits(input int presc, input int b0,
                           input int b1, input int emax);
    int mid;
    mid = presc / 2;
    for (int b = b0; b <= b1; b++) begin
`ifdef UART_RX_TRIPLE_SAMPLE_EN
      for (int e = mid - 1; e <= mid + 1; e++)
        if (e <= emax)
          stb_q.push_back(b * 1024 + e * 2 + ((e == mid + 1) ? 1 : 0));
`else
      if (mid <= emax) stb_q.push_back(b * 1024 + mid * 2 + 1);
`endif
    end
  endtask

  task automatic set_cfg(input int presc, input int dlen,
                         input int par, input int stop2);
    bus.Prescale = 6'(presc);
    bus.Data_Len = 4'(dlen);
    bus.Par_En   = 1'(par);
    bus.Stop2    = 1'(stop2);
  endtask

  task automatic run_frame(input int presc, input int dlen,
                           input int par, input int stop2,
                           input int alt, input string tag);
    int flen;
    flen = 2 + dlen + par + stop2;
    set_cfg(presc, dlen, par, stop2);
    push_bits(presc, 0, flen - 1, presc);
    fe_q.push_back(presc * flen * 65536 + (flen - 1) * 256 + presc);
    fe_seen = 0;
    bus.EN = 1'b1;
    cyc();
    check({tag, "_busy"}, int'(bus.busy), 1);
    check({tag, "_bit0"}, int'(bus.bit_count), 0);
    check({tag, "_edge1"}, int'(bus.edge_count), 1);
    for (int i = 0; i < presc * flen + 20 && fe_seen == 0; i++) begin
      cyc();
      if (alt != 0 && i == 20) bus.Prescale = 6'(alt);
    end
    check({tag, "_fe_seen"}, fe_seen, 1);
    check({tag, "_done_busy"}, int'(bus.busy), 0);
    check({tag, "_done_bit"}, int'(bus.bit_count), flen - 1);
    check({tag, "_done_edge"}, int'(bus.edge_count), 1);
    check({tag, "_done_eend"}, int'(bus.edge_end), 0);
    cyc();
    check({tag, "_hold_busy"}, int'(bus.busy), 0);
    check({tag, "_hold_bit"}, int'(bus.bit_count), flen - 1);
    bus.EN = 1'b0;
    cyc();
    check({tag, "_idle_bit"}, int'(bus.bit_count), 0);
    check({tag, "_idle_edge"}, int'(bus.edge_count), 1);
    check({tag, "_q_empty"}, stb_q.size() + fe_q.size(), 0);
  endtask

  task automatic cfg_case(input int presc, input int dlen,
                          input string tag);
    set_cfg(presc, dlen, 0, 0);
    bus.EN = 1'b1;
    cyc();
    cyc();
    check({tag, "_err"}, int'(bus.cfg_err), 1);
    check({tag, "_busy"}, int'(bus.busy), 0);
    rst = 1'b1;
    bus.EN = 1'b0;
    cyc();
    check({tag, "_err_clr"}, int'(bus.cfg_err), 0);
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int found;
    rst = 1'b1;
    bus.EN = 1'b0;
    set_cfg(8, 8, 0, 0);
    cyc();
    bus.EN = 1'b1;
    cyc();
    check("rst_prio_busy", int'(bus.busy), 0);
    bus.EN = 1'b0;
    rst = 1'b0;
    cyc();
    check("rst_bit", int'(bus.bit_count), 0);
    check("rst_edge", int'(bus.edge_count), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_cfg_err", int'(bus.cfg_err), 0);
    check("rst_outs", int'({bus.edge_end, bus.sample_stb,
                            bus.sample_last, bus.frame_end}), 0);

    run_frame(8, 8, 0, 0, 0, "f8n1");
    run_frame(16, 7, 1, 1, 0, "f16p2");

    set_cfg(8, 8, 0, 0);
    push_bits(8, 0, 2, 8);
    push_bits(8, 3, 3, 4);
    bus.EN = 1'b1;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      cyc();
      if (bus.bit_count == 4'd3 && bus.edge_count == 6'd5) found = 1;
    end
    check("abort_reach", found, 1);
    bus.EN = 1'b0;
    cyc();
    check("abort_busy", int'(bus.busy), 0);
    check("abort_bit", int'(bus.bit_count), 0);
    check("abort_edge", int'(bus.edge_count), 1);
    check("abort_q", stb_q.size() + fe_q.size(), 0);
    run_frame(8, 5, 0, 0, 0, "restart");

    run_frame(8, 8, 0, 0, 16, "pchg");
    run_frame(16, 8, 0, 0, 0, "pnext");
    run_frame(4, 5, 0, 0, 0, "pmin");
    run_frame(9, 8, 1, 1, 0, "odd");

    cfg_case(3, 8, "cfg_p3");
    cfg_case(8, 4, "cfg_d4");
    cfg_case(8, 9, "cfg_d9");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_timer.md
Name: uart_rx_frame_timer

Overview:
- Parametrised successor to the UART RX edge/bit counter.
- Counts oversampling edges per bit and bits per frame, with run-time frame format (data length, parity, 1/2 stop bits).
- Emits mid-bit sample strobes and an end-of-frame pulse.
- Sits between the RX FSM (drives EN) and the data sampler / deserializer (consume strobes and bit_count).

Parameters:
- PRESC_W, 6, width of Prescale and edge_count; max oversampling ratio 2^PRESC_W-1.
- BIT_W, 4, width of bit_count; must satisfy 2^BIT_W > MAX_DATA+4.
- MAX_DATA, 8, largest legal Data_Len.
- MIN_PRESC, 4, smallest legal Prescale.

Ports:
- CLK  in  1  clock, single clock domain.
- Reset  in  1  synchronous, active-high reset.
- EN  in  1  run enable from RX FSM; high for the whole frame.
- Prescale  in  PRESC_W  oversampling edges per bit.
- Data_Len  in  BIT_W  data bits per frame, 5..MAX_DATA.
- Par_En  in  1  parity bit present.
- Stop2  in  1  two stop bits when 1, else one.
- bit_count  out  BIT_W  index of the current bit; 0 = start bit.
- edge_count  out  PRESC_W  edge within the current bit, 1..presc_q.
- edge_end  out  1  last edge of the current bit (combinational).
- sample_stb  out  1  sampler capture strobe (combinational).
- sample_last  out  1  last strobe of the current bit (combinational).
- frame_end  out  1  last edge of the final stop bit (combinational).
- busy  out  1  state is COUNT.
- cfg_err  out  1  sticky: an illegal config was seen at frame start.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state IDLE, bit_count 0, edge_count 1, presc_q 0, flen_q 0, cfg_err 0. All combinational outputs are 0 in IDLE.
- States: IDLE, COUNT, DONE.
- IDLE, EN=1, config legal:
  - Latch presc_q = Prescale.
  - Latch flen_q = 1 + Data_Len + Par_En + 1 + Stop2.
  - Go to COUNT with bit_count=0, edge_count=1.
  - First COUNT cycle is edge 1 of the start bit (one-cycle start latency).
- Legal config: Prescale >= MIN_PRESC and 5 <= Data_Len <= MAX_DATA.
- IDLE, EN=1, config illegal: set cfg_err=1 and stay IDLE. cfg_err clears only on Reset.
- COUNT, each cycle with EN=1:
  - edge_end = (edge_count == presc_q).
  - If edge_end: edge_count <= 1 and bit_count <= bit_count+1.
  - Otherwise: edge_count <= edge_count+1.
- Final bit: when edge_end and bit_count == flen_q-1:
  - frame_end=1 in the same cycle.
  - Next state DONE; bit_count holds at flen_q-1 and edge_count <= 1.
- DONE: counters frozen, outputs 0. Go to IDLE when EN=0. A new frame needs EN low for at least 1 cycle.
- EN=0 in any state (including mid-frame abort): next cycle state IDLE, bit_count 0, edge_count 1. Outputs are gated off in the same cycle EN drops.
- Prescale/config changes during COUNT are ignored; only the latched values are used.
- Sample point: mid = presc_q >> 1 (floor). Example: Prescale=8 gives mid=4; Prescale=9 gives mid=4.
- Arithmetic: all compares unsigned; bit_count never wraps because flen_q <= MAX_DATA+4 < 2^BIT_W.
- Reset has priority over EN in every state.

Optional Feature:
- Macro: UART_RX_TRIPLE_SAMPLE_EN.
- Defined: sample_stb pulses at edge_count == mid-1, mid and mid+1 (3 strobes per bit, for majority vote). sample_last is high only at mid+1. MIN_PRESC is effectively 4, which guarantees mid+1 <= presc_q.
- Undefined: a single sample_stb at edge_count == mid; sample_last equals sample_stb.

Decomposition:
- Package uart_rx_pkg holds:
  - State typedef (IDLE/COUNT/DONE).
  - Constants: START_BITS=1, STOP_BITS_MIN=1.
  - Frame-length helper function.
- One natural sub-module, uart_rx_edge_ctr: the presc_q-modulo edge counter, producing edge_count and edge_end. The parent owns the FSM, bit counter and strobe decode.

Test Plan:
- Prescale=8, Data_Len=8, Par_En=0, Stop2=0, EN held high:
  - edge_end every 8 cycles.
  - bit_count runs 0..9.
  - frame_end on cycle 80 after COUNT entry, then DONE.
- Prescale=16, Data_Len=7, Par_En=1, Stop2=1: flen=11; frame_end at bit_count=10, edge 16.
- Prescale=8, macro on: sample_stb at edges 3,4,5 of every bit, with sample_last at edge 5. Macro off: single strobe at edge 4.
- EN dropped at bit_count=3, edge 5: next cycle state IDLE, bit_count=0, edge_count=1, no frame_end. Re-raising EN starts a clean frame.
- Prescale=3 or Data_Len=4 with EN=1: cfg_err=1, busy stays 0. Reset (synchronous) then clears cfg_err on the next edge.
- Prescale changed from 8 to 16 mid-frame: bit period stays 8 until DONE; the next frame uses 16.
